image_stream_reader: RTL

- Downstream consumer of the 784-entry image memory: on a start pulse, scans addresses 0..NUM_PIXELS-1 and streams each 32-bit pixel word to the first network layer over a valid/ready handshake.
- Hides the memory's one-cycle registered read latency.
- Absorbs consumer backpressure with a small output FIFO, so the layer can stall at any cycle without losing or duplicating pixels.

---
 rtl/nn_pkg.sv | 30 +++
 rtl/stream_fifo.sv | 62 ++++++
 rtl/image_stream_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the image-to-network datapath.
//   NUM_PIXELS / ADDR_W / DATA_W / IDX_W : image geometry and bus widths
//   scan_state_t : sequencing states, also used by the layer controller
//   pix_word_t   : one buffered pixel (data, source index, last marker)
package nn_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int IDX_W      = 10;
  localparam int PIX_W      = DATA_W + IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic              last;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
  } pix_word_t;

  // Unsigned compare of a full-width address against the final pixel.
  function automatic logic is_last_addr(input logic [ADDR_W-1:0] addr);
    return addr == ADDR_W'(NUM_PIXELS - 1);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with occupancy count and synchronous flush.
//   clk, reset_n : clock, async active-low reset
//   flush        : empties the FIFO on the next edge (wins over push/pop)
//   push, wdata  : write request and data
//   pop          : consume the head entry (ignored when empty)
//   rdata        : head entry, valid whenever empty=0
//   empty, count : occupancy status
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
  assign rdata   = slots[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= wdata;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/image_stream_reader.sv
// Scans the image memory 0..NUM_PIXELS-1 after a start pulse and streams the
// pixel words to the first layer over valid/ready, hiding the memory's
// registered read latency and absorbing backpressure in a small FIFO.
//   clk, reset_n          : clock, async active-low reset
//   start, abort          : begin a scan when idle / cancel a running scan
//   mem_address, mem_data : image memory read port (1-cycle registered read)
//   pix_valid, pix_ready  : output handshake
//   pix_data/index/last   : pixel word, its address, final-pixel marker
//   busy, done            : scan in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start, nothing in flight
// RUN   | issuing addresses, throttled by the buffer budget
// DRAIN | all addresses issued, waiting for the last pixel handshake
module image_stream_reader
  import nn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [IDX_W-1:0]  pix_index,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  scan_state_t       state_q;
  scan_state_t       state_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] issue_addr;
  logic              s1_valid;
  logic              s2_valid;
  logic [IDX_W-1:0]  s1_index;
  logic [IDX_W-1:0]  s2_index;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  pix_word_t         push_word;
  pix_word_t         head_word;
  logic              handshake;
  logic              flush;
  logic              start_ok;
  logic              can_issue;
  logic              issue;
  logic              last_issue;
  logic              last_pop;

  assign handshake = pix_valid & pix_ready;
  assign flush     = abort & (state_q != IDLE);
  assign start_ok  = (state_q == IDLE) & start & ~abort;

  // Reserve a FIFO slot for every read already in flight so a captured word
  // always has somewhere to land, even if the consumer stalls forever.
  assign can_issue = (int'(fifo_count) + int'(s1_valid) + int'(s2_valid) + 1)
                     <= FIFO_DEPTH;

  assign issue      = start_ok | ((state_q == RUN) & ~abort & can_issue);
  assign issue_addr = start_ok ? '0 : rd_addr + ADDR_W'(1);
  assign last_issue = issue & is_last_addr(issue_addr);
  assign last_pop   = (state_q == DRAIN) & handshake & pix_last & ~abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = last_issue ? DRAIN : RUN;
      end
      RUN: begin
        if (abort)           state_d = IDLE;
        else if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)         state_d = IDLE;
        else if (last_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    mem_address = rd_addr;
    pix_valid   = ~fifo_empty;
    pix_data    = head_word.data;
    pix_index   = head_word.index;
    pix_last    = head_word.last;
  end

  // s1: address on the memory bus; s2: memory has sampled it and mem_data
  // carries the word, which is pushed on the following edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr  <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_index <= '0;
      s2_index <= '0;
      done     <= 1'b0;
    end else begin
      done <= last_pop;
      if (flush) begin
        rd_addr  <= '0;
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (issue) rd_addr <= issue_addr;
        s1_valid <= issue;
        s1_index <= issue_addr[IDX_W-1:0];
        s2_valid <= s1_valid;
        s2_index <= s1_index;
      end
    end
  end

  always_comb begin
    push_word.last  = (s2_index == IDX_W'(NUM_PIXELS - 1));
    push_word.index = s2_index;
    push_word.data  = mem_data;
  end

  stream_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (s2_valid),
    .wdata   (push_word),
    .pop     (handshake),
    .rdata   (head_word),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
